mem_line_arbiter: RTL and testbench
===================================

# mem_line_arbiter

Backing-memory controller for the WISC-S15 pipeline. It accepts cache-line miss traffic from the instruction cache (read-only) and the data cache (read/write), arbitrates between them, and services one line access at a time with a fixed multi-cycle latency. The I-cache and D-cache controllers are its only clients, and its response data feeds their line-fill paths.

## Interface
Parameters:
- ADDR_W, 16, byte/word address width of request addresses
- LINE_W, 64, line width in bits (4 x 16-bit words)
- LINES, 1024, number of lines in the internal storage array
- LATENCY, 4, access cycles per request (legal range 1..15)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  I-cache line read request
- i_req_addr  in  ADDR_W  I-cache request address
- i_req_ready  out  1  I request accepted this cycle when high together with i_req_valid
- d_req_valid  in  1  D-cache request
- d_req_rw  in  1  1 = line write, 0 = line read
- d_req_addr  in  ADDR_W  D-cache request address
- d_req_wdata  in  LINE_W  write line data
- d_req_ready  out  1  D request accepted this cycle when high together with d_req_valid
- i_resp_valid  out  1  one-cycle pulse, I read data valid
- i_resp_data  out  LINE_W  I read line
- d_resp_valid  out  1  one-cycle pulse, D read data or write acknowledge
- d_resp_data  out  LINE_W  D read line; echoes written data on a write ack
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Ready is combinational and goes only to the granted requester.
  - D-only pending: grant D. I-only pending: grant I.
  - Both pending: grant the port not granted last (`last_grant`). `last_grant` resets to I, so D wins the first tie.
  - On handshake, latch port, rw, line index, and wdata; set `cnt = LATENCY-1`; go to ACCESS; update `last_grant`.
- ACCESS: decrement `cnt` each cycle. When `cnt == 0`, perform the array operation and go to RESP.
  - Read: latch the array line into the response register.
  - Write: update the array line and latch wdata into the response register.
- RESP: assert the owning port's resp_valid for exactly one cycle, then go to IDLE.
- Line index is `addr[ADDR_W-1:2] mod LINES`. Address bits [1:0] (word offset) are ignored; upper bits beyond the index alias.
- I requests are always reads.
- Both ready outputs are 0 outside IDLE. Requests held valid while not ready simply wait; no queuing beyond the single latched request.
- The array is zero at time 0 and is not cleared by rst.

## Timing
- Reset values: state IDLE, `cnt` 0, `last_grant` I, i_resp_valid 0, d_resp_valid 0, i_resp_data 0, d_resp_data 0, busy 0.
- i_req_ready and d_req_ready are 0 during rst.
- Request accepted in cycle T. ACCESS occupies T+1..T+LATENCY. resp_valid is high in cycle T+LATENCY+1. The next accept is possible at T+LATENCY+2.
- Throughput is one request per LATENCY+2 cycles.
- Response data registers hold their value after the pulse until the next response for that port.
- A write is visible to any read accepted after its ack cycle.
- Reset during ACCESS or RESP:
  - The request is aborted and no resp_valid is issued.
  - A write whose array update has not yet occurred is discarded.
  - The FSM returns to IDLE next cycle.
- Simultaneous valid on both ports with `last_grant` = D: I is granted. D's ready stays 0 and D waits, then is granted at the next IDLE.

## Test plan
- Reset, then I read addr 0x0040 -> i_req_ready in the accept cycle; i_resp_valid exactly 5 cycles later (LATENCY=4) with data 0; busy high for 5 cycles.
- D write addr 0x0008, data 0x1111_2222_3333_4444 -> d_resp_valid 5 cycles after accept, echoing the data. Then a D read of addr 0x000B (same line) -> returns 0x1111_2222_3333_4444.
- I and D valid together from reset -> D granted first, I granted in the IDLE cycle after D's response. Repeat with both continuously valid -> grants alternate D, I, D, I.
- Assert rst in the 2nd ACCESS cycle of a D write to 0x0010 -> no d_resp_valid; a subsequent read of 0x0010 returns 0.
- Aliasing with LINES=1024: write to 0x0004, then read 0x1004 -> returns the written line.
- Hold i_req_valid during a busy D access -> i_req_ready stays 0 until IDLE; the I request is then served once only.

Source files
------------

// File: rtl/mem_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_line_arbiter
// Brief    : Two-client (I-cache read, D-cache read/write) line memory with
//            fair tie arbitration and fixed multi-cycle access latency.
// Revision : 1.0 - initial release
// ============================================================================
module mem_line_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 64,
  parameter int LINES   = 1024,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  input  logic              d_req_valid,
  input  logic              d_req_rw,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              i_resp_valid,
  output logic [LINE_W-1:0] i_resp_data,
  output logic              d_resp_valid,
  output logic [LINE_W-1:0] d_resp_data,
  output logic              busy
);

  localparam int         IDX_W    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic       PORT_I   = 1'b0;
  localparam logic       PORT_D   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                port_q, port_d;
  logic                rw_q, rw_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;

  // Line storage; never touched by rst, relies on zero power-up contents.
  logic [LINE_W-1:0]   mem_q [LINES];

  logic                grant_i;
  logic                grant_d;
  logic                mem_we;
  logic [IDX_W-1:0]    i_idx;
  logic [IDX_W-1:0]    d_idx;
  logic                unused_addr_bits;

  // Word offset bits never select anything; the line index wraps modulo LINES.
  function automatic logic [IDX_W-1:0] line_index(input logic [ADDR_W-1:0] addr);
    logic [31:0] word;
    word = 32'(addr[ADDR_W-1:2]);
    return IDX_W'(word % 32'(LINES));
  endfunction

  assign i_idx            = line_index(i_req_addr);
  assign d_idx            = line_index(d_req_addr);
  assign unused_addr_bits = ^{i_req_addr[1:0], d_req_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    rw_d         = rw_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the port that did not win last time gets the grant.
        if (d_req_valid && (!i_req_valid || (last_grant_q == PORT_I))) begin
          grant_d = 1'b1;
        end else if (i_req_valid) begin
          grant_i = 1'b1;
        end

        if (grant_i || grant_d) begin
          port_d       = grant_d ? PORT_D : PORT_I;
          rw_d         = grant_d & d_req_rw;
          idx_d        = grant_d ? d_idx : i_idx;
          wdata_d      = d_req_wdata;
          cnt_d        = CNT_INIT;
          last_grant_d = grant_d ? PORT_D : PORT_I;
          state_d      = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          if (rw_q) begin
            mem_we    = 1'b1;
            d_rdata_d = wdata_q;
          end else if (port_q == PORT_D) begin
            d_rdata_d = mem_q[idx_q];
          end else begin
            i_rdata_d = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= PORT_I;
      port_q       <= PORT_I;
      rw_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      rw_q         <= rw_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // A reset landing on the update cycle discards the pending write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign i_req_ready  = grant_i & ~rst;
  assign d_req_ready  = grant_d & ~rst;
  assign i_resp_valid = (state_q == ST_RESP) && (port_q == PORT_I) && !rst;
  assign d_resp_valid = (state_q == ST_RESP) && (port_q == PORT_D) && !rst;
  assign i_resp_data  = i_rdata_q;
  assign d_resp_data  = d_rdata_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_line_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_line_arbiter
// Brief    : Scenario and randomized checks of mem_line_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_line_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 64;
  localparam int LINES  = 1024;
  localparam int LAT    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic              d_req_valid;
  logic              d_req_rw;
  logic [ADDR_W-1:0] d_req_addr;
  logic [LINE_W-1:0] d_req_wdata;
  logic              d_req_ready;
  logic              i_resp_valid;
  logic [LINE_W-1:0] i_resp_data;
  logic              d_resp_valid;
  logic [LINE_W-1:0] d_resp_data;
  logic              busy;

  int errors = 0;
  int checks = 0;

  // Reference line store: absent key means the line still holds zero.
  logic [LINE_W-1:0] ref_mem [int];

  mem_line_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .LINES(LINES), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .d_req_valid(d_req_valid), .d_req_rw(d_req_rw), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_idx(input logic [ADDR_W-1:0] a);
    return int'({16'd0, a} >> 2) % LINES;
  endfunction

  function automatic logic [LINE_W-1:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; i_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issues one request from idle; reports what the DUT did, compares nothing.
  task automatic txn(input logic is_d, input logic rw, input logic [ADDR_W-1:0] addr,
                     input logic [LINE_W-1:0] wd, output int lat, output logic [LINE_W-1:0] data,
                     output int busy_n, output int pulses, output int other);
    int w;
    lat = -1; data = '0; busy_n = 0; pulses = 0; other = 0; w = 0;
    if (is_d) begin
      d_req_valid = 1'b1; d_req_rw = rw; d_req_addr = addr; d_req_wdata = wd;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    @(negedge clk);
    while (!(is_d ? d_req_ready : i_req_ready) && w < 50) begin
      @(negedge clk); w++;
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    if (w >= 50) return;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (is_d ? d_resp_valid : i_resp_valid) begin
        pulses++;
        if (lat < 0) begin lat = k; data = is_d ? d_resp_data : i_resp_data; end
      end
      if (is_d ? i_resp_valid : d_resp_valid) other++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req_valid = 1'b1; d_req_valid = 1'b1; d_req_rw = 1'b1;
    i_req_addr = 16'h0040; d_req_addr = 16'h0040; d_req_wdata = {16{4'hF}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({i_req_ready, d_req_ready, busy, i_resp_valid, d_resp_valid} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl: got %b expected 00000 (i_rdy d_rdy busy i_rv d_rv)",
                 {i_req_ready, d_req_ready, busy, i_resp_valid, d_resp_valid});
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({i_resp_data, d_resp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got i=%h d=%h expected 0", i_resp_data, d_resp_data);
    end
    rst = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_read();
    int lat, bn, pn, on; logic [LINE_W-1:0] data;
    txn(1'b0, 1'b0, 16'h0040, '0, lat, data, bn, pn, on);
    checks++;
    if (lat !== LAT + 1) begin errors++; $display("FAIL read_latency: got %0d expected %0d", lat, LAT + 1); end
    checks++;
    if (data !== ref_rd(ref_idx(16'h0040))) begin errors++; $display("FAIL read_zero: got %h expected 0", data); end
    checks++;
    if (bn !== LAT + 1) begin errors++; $display("FAIL read_busy: got %0d cycles expected %0d", bn, LAT + 1); end
    checks++;
    if ({pn, on} !== {32'd1, 32'd0}) begin errors++; $display("FAIL read_pulses: got own=%0d other=%0d expected 1/0", pn, on); end
  endtask

  task automatic test_write_read();
    int lat, bn, pn, on; logic [LINE_W-1:0] data;
    logic [LINE_W-1:0] wd = 64'h1111_2222_3333_4444;
    txn(1'b1, 1'b1, 16'h0008, wd, lat, data, bn, pn, on);
    ref_mem[ref_idx(16'h0008)] = wd;
    checks++;
    if (lat !== LAT + 1 || pn !== 1) begin errors++; $display("FAIL write_ack: got lat=%0d pulses=%0d expected %0d/1", lat, pn, LAT + 1); end
    checks++;
    if (data !== wd) begin errors++; $display("FAIL write_echo: got %h expected %h", data, wd); end
    txn(1'b1, 1'b0, 16'h000B, '0, lat, data, bn, pn, on);
    checks++;
    if (data !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL same_line_read: got %h expected %h", data, wd); end
  endtask

  task automatic test_alias();
    int lat, bn, pn, on; logic [LINE_W-1:0] data;
    logic [LINE_W-1:0] wd = {$urandom, $urandom};
    txn(1'b1, 1'b1, 16'h0004, wd, lat, data, bn, pn, on);
    ref_mem[ref_idx(16'h0004)] = wd;
    txn(1'b0, 1'b0, 16'h1004, '0, lat, data, bn, pn, on);
    checks++;
    if (data !== wd) begin errors++; $display("FAIL alias_read: got %h expected %h", data, wd); end
    txn(1'b1, 1'b0, 16'h0008, '0, lat, data, bn, pn, on);
    checks++;
    if (data !== ref_rd(2)) begin errors++; $display("FAIL d_read_line2: got %h expected %h", data, ref_rd(2)); end
    checks++;
    if (i_resp_data !== wd) begin errors++; $display("FAIL i_data_hold: got %h expected %h", i_resp_data, wd); end
  endtask

  task automatic test_reset_abort();
    int lat, bn, pn, on, w, spurious; logic [LINE_W-1:0] data;
    d_req_valid = 1'b1; d_req_rw = 1'b1; d_req_addr = 16'h0010; d_req_wdata = {$urandom, 32'h1};
    w = 0;
    @(negedge clk);
    while (!d_req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1 d_req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    spurious = 0;
    @(negedge clk);
    if (d_resp_valid) spurious++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b expected 0", busy); end
    for (int k = 0; k < LAT + 4; k++) begin
      if (d_resp_valid) spurious++;
      @(negedge clk);
    end
    checks++;
    if (spurious !== 0 || w >= 50) begin errors++; $display("FAIL abort_no_resp: got pulses=%0d wait=%0d expected 0", spurious, w); end
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 16'h0010, '0, lat, data, bn, pn, on);
    checks++;
    if (data !== ref_rd(ref_idx(16'h0010)) || lat !== LAT + 1) begin
      errors++; $display("FAIL abort_discard: got data=%h lat=%0d expected 0/%0d", data, lat, LAT + 1);
    end
  endtask

  task automatic test_tie_alternate();
    int g_t[4]; logic g_d[4]; int n, both, d_resp_t;
    do_reset();
    i_req_valid = 1'b1; i_req_addr = 16'h0100;
    d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 16'h0200;
    n = 0; both = 0; d_resp_t = -1;
    for (int t = 0; t < 40 && n < 4; t++) begin
      @(negedge clk);
      if (i_req_ready && d_req_ready) both++;
      if (d_resp_valid && d_resp_t < 0) d_resp_t = t;
      if (d_req_ready || i_req_ready) begin g_t[n] = t; g_d[n] = d_req_ready; n++; end
      @(posedge clk); #1;
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    checks++;
    if (n !== 4 || both !== 0) begin errors++; $display("FAIL tie_grants: got %0d grants, %0d double expected 4/0", n, both); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (g_d[k] !== ((k % 2) == 0) || g_t[k] !== k * (LAT + 2)) begin
        errors++;
        $display("FAIL tie_order%0d: got port_d=%b t=%0d expected %b/%0d", k, g_d[k], g_t[k], (k % 2) == 0, k * (LAT + 2));
      end
    end
    checks++;
    if (d_resp_t !== LAT + 1) begin errors++; $display("FAIL tie_d_resp: got t=%0d expected %0d", d_resp_t, LAT + 1); end
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_hold_i();
    int i_acc, dup, i_resp_n, i_resp_t; logic d_first; logic [LINE_W-1:0] i_data;
    logic [LINE_W-1:0] wd = {$urandom, $urandom};
    d_req_valid = 1'b1; d_req_rw = 1'b1; d_req_addr = 16'h0020; d_req_wdata = wd;
    i_acc = -1; dup = 0; i_resp_n = 0; i_resp_t = -1; d_first = 1'b0; i_data = '0;
    for (int t = 0; t < 2 * (LAT + 2) + 6; t++) begin
      @(negedge clk);
      if (t == 0) d_first = d_req_ready;
      if (i_req_valid && i_req_ready) begin
        if (i_acc < 0) i_acc = t; else dup++;
      end
      if (i_resp_valid) begin i_resp_n++; i_resp_t = t; i_data = i_resp_data; end
      @(posedge clk); #1;
      if (t == 0) begin d_req_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 16'h0022; end
      if (i_acc >= 0) i_req_valid = 1'b0;
    end
    ref_mem[ref_idx(16'h0020)] = wd;
    checks++;
    if (d_first !== 1'b1 || i_acc !== LAT + 2) begin
      errors++; $display("FAIL hold_i_accept: got d_rdy=%b i_acc=%0d expected 1/%0d", d_first, i_acc, LAT + 2);
    end
    checks++;
    if (i_resp_n !== 1 || dup !== 0 || i_resp_t !== 2 * LAT + 3) begin
      errors++; $display("FAIL hold_i_once: got resp=%0d dup=%0d t=%0d expected 1/0/%0d", i_resp_n, dup, i_resp_t, 2 * LAT + 3);
    end
    checks++;
    if (i_data !== wd) begin errors++; $display("FAIL hold_i_data: got %h expected %h", i_data, wd); end
  endtask

  // Random traffic scored against a timing model: one request per LAT+2 cycles,
  // response LAT+1 cycles after the accept, ties going to the port not last served.
  task automatic test_random();
    int free_at, acc_t, due_t; logic last_d, due_d, exp_i, exp_d, exp_busy, i_drop, d_drop;
    logic [LINE_W-1:0] due_data;
    do_reset();
    free_at = 0; acc_t = -1; due_t = -1; last_d = 1'b0; due_d = 1'b0; due_data = '0;
    i_drop = 1'b0; d_drop = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(posedge clk); #1;
      if (i_drop) begin i_req_valid = 1'b0; i_drop = 1'b0; end
      if (d_drop) begin d_req_valid = 1'b0; d_drop = 1'b0; end
      if (!i_req_valid && $urandom_range(0, 3) == 0) begin
        i_req_valid = 1'b1;
        i_req_addr = {4'($urandom_range(0, 15)), 10'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      end
      if (!d_req_valid && $urandom_range(0, 2) == 0) begin
        d_req_valid = 1'b1; d_req_rw = 1'($urandom_range(0, 1)); d_req_wdata = {$urandom, $urandom};
        d_req_addr = {4'($urandom_range(0, 15)), 10'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      end
      @(negedge clk);
      exp_i = 1'b0; exp_d = 1'b0;
      if (t >= free_at) begin
        if (d_req_valid && (!i_req_valid || !last_d)) exp_d = 1'b1;
        else if (i_req_valid) exp_i = 1'b1;
      end
      exp_busy = (acc_t >= 0) && (t > acc_t) && (t < free_at);
      checks++;
      if ({i_req_ready, d_req_ready, busy} !== {exp_i, exp_d, exp_busy}) begin
        errors++;
        $display("FAIL rnd_ctrl t=%0d: got rdy_i/rdy_d/busy=%b expected %b", t, {i_req_ready, d_req_ready, busy}, {exp_i, exp_d, exp_busy});
      end
      checks++;
      if ({i_resp_valid, d_resp_valid} !== {(due_t == t) && !due_d, (due_t == t) && due_d}) begin
        errors++;
        $display("FAIL rnd_resp t=%0d: got i_rv/d_rv=%b expected %b", t, {i_resp_valid, d_resp_valid}, {(due_t == t) && !due_d, (due_t == t) && due_d});
      end
      if (due_t == t) begin
        checks++;
        if ((due_d ? d_resp_data : i_resp_data) !== due_data) begin
          errors++;
          $display("FAIL rnd_data t=%0d: got %h expected %h", t, due_d ? d_resp_data : i_resp_data, due_data);
        end
      end
      if (exp_i || exp_d) begin
        acc_t = t; free_at = t + LAT + 2; due_t = t + LAT + 1; last_d = exp_d; due_d = exp_d;
        if (exp_d && d_req_rw) begin
          ref_mem[ref_idx(d_req_addr)] = d_req_wdata; due_data = d_req_wdata;
        end else begin
          due_data = ref_rd(ref_idx(exp_d ? d_req_addr : i_req_addr));
        end
        i_drop = exp_i; d_drop = exp_d;
      end
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_rw = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic_read();
    test_write_read();
    test_alias();
    test_reset_abort();
    test_tie_alternate();
    test_hold_i();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
